ysyx_23060191_mem_arb: RTL and testbench
========================================

// Module: ysyx_23060191_mem_arb
// PURPOSE
//   Arbitrates the single simulated-memory port between the instruction-fetch requester (IF, read-only)
//   and the load/store requester (LS, read/write). Serves one transaction at a time through a 4-state FSM.
//   Uses valid/ready handshakes on both requester sides and on the memory side.
//   A watchdog error-terminates a transaction whose memory response never arrives.
// PARAMETERS
//   AW       32   address width
//   DW       32   data width; must be a multiple of 8, wmask width = DW/8
//   TIMEOUT  255  max cycles in WAIT before error termination (1..2^16-1)
// PORTS
//   clk            in   1     clock, rising edge
//   rst_n          in   1     asynchronous active-low reset
//   if_req_valid   in   1     IF read request
//   if_req_ready   out  1     IF request accepted this cycle
//   if_addr        in   AW    IF read address
//   if_rsp_valid   out  1     IF response available
//   if_rsp_ready   in   1     IF consumes response
//   if_rdata       out  DW    IF read data
//   if_rsp_err     out  1     IF transaction timed out
//   ls_req_valid   in   1     LS request
//   ls_req_ready   out  1     LS request accepted this cycle
//   ls_addr        in   AW    LS address
//   ls_wen         in   1     1=write, 0=read
//   ls_wdata       in   DW    LS write data
//   ls_wmask       in   DW/8  LS byte-lane write enables
//   ls_rsp_valid   out  1     LS response available (reads and writes)
//   ls_rsp_ready   in   1     LS consumes response
//   ls_rdata       out  DW    LS read data; 0 for writes
//   ls_rsp_err     out  1     LS transaction timed out
//   mem_req_valid  out  1     request to memory
//   mem_req_ready  in   1     memory accepts request
//   mem_addr       out  AW    registered address
//   mem_wen        out  1     registered write enable
//   mem_wdata      out  DW    registered write data
//   mem_wmask      out  DW/8  registered write mask; all-0 for reads
//   mem_rsp_valid  in   1     memory response strobe
//   mem_rdata      in   DW    memory read data, valid with mem_rsp_valid
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; owner, all regs, watchdog counter and rr pointer cleared;
//     every output is 0. A reset mid-transaction abandons it silently; no response is ever issued.
//   FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   IDLE: if_req_ready/ls_req_ready are combinational grants, at most one high, and only when that
//     requester's valid is high. On grant, latch addr/wen/wdata/wmask and owner; go to REQ.
//     For IF: wen=0, wmask=0.
//   REQ: mem_req_valid=1. On mem_req_ready, go to WAIT and clear the counter.
//   WAIT: counter increments each cycle.
//     - mem_rsp_valid: capture mem_rdata (0 if write), err=0, go to RESP.
//     - Counter reaches TIMEOUT without response: rdata=0, err=1, go to RESP.
//     - mem_rsp_valid arriving in the same cycle as the timeout wins (err=0).
//   RESP: owner's rsp_valid=1 with held rdata/err; other requester's rsp_valid=0.
//     On owner's rsp_ready, go to IDLE. rsp_valid is never dropped before ready.
//   Both req_ready are 0 outside IDLE. mem_rsp_valid outside WAIT is ignored.
//   Requester inputs are only sampled at grant; changes afterwards do not affect the transaction.
//   Latency (memory ready and responding at once): grant at cycle N -> rsp_valid at N+3.
//     Minimum transaction period is 4 cycles.
//   The counter is 16 bits and saturates; it does not wrap.
// CONFIGURATION
//   YSYX_23060191_ARB_RR_EN
//     Undefined: fixed priority; LS wins when both valids are high in IDLE.
//     Defined: round-robin. A 1-bit pointer names the preferred requester on conflict.
//       After each grant the pointer flips to the non-granted side.
//       Pointer reset value = IF preferred. A lone requester is always granted.
// TESTING
//   T1 IF read addr 0x80000000, memory returns 0x00000413 after 2 cycles
//      -> if_rsp_valid with if_rdata=0x00000413, err=0; ls_rsp_valid stays 0.
//   T2 LS write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF
//      -> mem_wen=1, mem_wmask=0xF in REQ; ls_rsp_valid with rdata=0, err=0.
//   T3 IF and LS valid together for 4 transactions
//      -> fixed: LS granted every time;
//      -> RR_EN: grants IF, LS, IF, LS.
//   T4 mem_rsp_valid never asserted, TIMEOUT=8
//      -> RESP entered 8 cycles after WAIT; owner rdata=0, err=1.
//   T5 if_rsp_ready held 0 for 5 cycles in RESP
//      -> if_rsp_valid and if_rdata stable; no new grant until the ready handshake.
//   T6 rst_n pulsed low during WAIT
//      -> all outputs 0 immediately; the late mem_rsp_valid is ignored; the next request proceeds normally.

Source files
------------

// File: rtl/ysyx_23060191_mem_arb_if.sv
// Signal bundle for the memory arbiter: IF requester, LS requester and memory port.
// The slave modport is the arbiter's view; master is the surrounding system (requesters + memory).
interface ysyx_23060191_mem_arb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // instruction-fetch requester (read-only)
   logic            if_req_valid;
   logic            if_req_ready;
   logic [AW-1:0]   if_addr;
   logic            if_rsp_valid;
   logic            if_rsp_ready;
   logic [DW-1:0]   if_rdata;
   logic            if_rsp_err;

   // load/store requester
   logic            ls_req_valid;
   logic            ls_req_ready;
   logic [AW-1:0]   ls_addr;
   logic            ls_wen;
   logic [DW-1:0]   ls_wdata;
   logic [DW/8-1:0] ls_wmask;
   logic            ls_rsp_valid;
   logic            ls_rsp_ready;
   logic [DW-1:0]   ls_rdata;
   logic            ls_rsp_err;

   // shared memory port
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [AW-1:0]   mem_addr;
   logic            mem_wen;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wmask;
   logic            mem_rsp_valid;
   logic [DW-1:0]   mem_rdata;

   modport master (
      output if_req_valid, if_addr, if_rsp_ready,
      output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ls_rsp_ready,
      output mem_req_ready, mem_rsp_valid, mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
      input  ls_req_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );

   modport slave (
      input  if_req_valid, if_addr, if_rsp_ready,
      input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ls_rsp_ready,
      input  mem_req_ready, mem_rsp_valid, mem_rdata,
      output if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
      output ls_req_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/ysyx_23060191_mem_arb.sv
// Single-port memory arbiter between IF (read-only) and LS (read/write), one transaction at a time,
// with a response watchdog. Define YSYX_23060191_ARB_RR_EN for round-robin; default is fixed LS priority.
module ysyx_23060191_mem_arb #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ysyx_23060191_mem_arb_if.slave bus
);
   localparam int          MW      = DW / 8;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   if ((DW % 8) != 0) begin : g_bad_dw
      $error("ysyx_23060191_mem_arb: DW must be a multiple of 8");
   end
   if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
      $error("ysyx_23060191_mem_arb: TIMEOUT must be in 1..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic [AW-1:0]   addr_q,  addr_d;
   logic            wen_q,   wen_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [MW-1:0]   wmask_q, wmask_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q,   err_d;
   logic [15:0]     cnt_q,   cnt_d;
`ifdef YSYX_23060191_ARB_RR_EN
   owner_e          rr_q,    rr_d;
`endif

   logic            grant_if;
   logic            grant_ls;
   logic            owner_rsp_ready;

   // Grants are combinational and gated by rst_n so every output reads 0 while reset is held.
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (rst_n && (state_q == S_IDLE)) begin
`ifdef YSYX_23060191_ARB_RR_EN
         if (bus.if_req_valid && bus.ls_req_valid) begin
            grant_if = (rr_q == OWN_IF);
            grant_ls = (rr_q == OWN_LS);
         end else begin
            grant_if = bus.if_req_valid;
            grant_ls = bus.ls_req_valid;
         end
`else
         grant_ls = bus.ls_req_valid;
         grant_if = bus.if_req_valid && !bus.ls_req_valid;
`endif
      end
   end

   assign owner_rsp_ready = (owner_q == OWN_LS) ? bus.ls_rsp_ready : bus.if_rsp_ready;

   // Register process: every flop, including the datapath, resets so outputs are 0 in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= OWN_IF;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef YSYX_23060191_ARB_RR_EN
         rr_q    <= OWN_IF;
`endif
      end else begin
         // NOTE: non-blocking assignments so all flops update together from pre-edge values.
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef YSYX_23060191_ARB_RR_EN
         rr_q    <= rr_d;
`endif
      end
   end

   // Next-state and datapath process.
   always_comb begin
      // NOTE: hold-value defaults first, so no path through the case leaves a signal unassigned (no latch).
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
`ifdef YSYX_23060191_ARB_RR_EN
      rr_d    = rr_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (grant_ls) begin
               owner_d = OWN_LS;
               addr_d  = bus.ls_addr;
               wen_d   = bus.ls_wen;
               wdata_d = bus.ls_wdata;
               wmask_d = bus.ls_wen ? bus.ls_wmask : '0;
               state_d = S_REQ;
            end else if (grant_if) begin
               owner_d = OWN_IF;
               addr_d  = bus.if_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               state_d = S_REQ;
            end
`ifdef YSYX_23060191_ARB_RR_EN
            // pointer moves to the side that lost (or was absent)
            if (grant_if) begin
               rr_d = OWN_LS;
            end else if (grant_ls) begin
               rr_d = OWN_IF;
            end
`endif
         end

         S_REQ: begin
            if (bus.mem_req_ready) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 16'd1;
            end
            // a response in the timeout cycle still completes without error
            if (bus.mem_rsp_valid) begin
               rdata_d = wen_q ? '0 : bus.mem_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q >= TO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            if (owner_rsp_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Output process.
   always_comb begin
      bus.if_req_ready  = grant_if;
      bus.ls_req_ready  = grant_ls;

      bus.mem_req_valid = (state_q == S_REQ);
      bus.mem_addr      = addr_q;
      bus.mem_wen       = wen_q;
      bus.mem_wdata     = wdata_q;
      bus.mem_wmask     = wmask_q;

      bus.if_rsp_valid  = (state_q == S_RESP) && (owner_q == OWN_IF);
      bus.if_rdata      = bus.if_rsp_valid ? rdata_q : '0;
      bus.if_rsp_err    = bus.if_rsp_valid && err_q;

      bus.ls_rsp_valid  = (state_q == S_RESP) && (owner_q == OWN_LS);
      bus.ls_rdata      = bus.ls_rsp_valid ? rdata_q : '0;
      bus.ls_rsp_err    = bus.ls_rsp_valid && err_q;
   end
endmodule

// File: tb/tb_ysyx_23060191_mem_arb.sv
// Directed self-checking bench for ysyx_23060191_mem_arb (TIMEOUT=8); the testbench plays both
// requesters and the memory. Honours YSYX_23060191_ARB_RR_EN for the conflict-grant expectations.
module tb_ysyx_23060191_mem_arb;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ysyx_23060191_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

   ysyx_23060191_mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in REQ: accept, wait `delay` WAIT cycles, then return `data`; leaves the DUT in RESP.
   task automatic serve(input int delay, input logic [31:0] data);
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      repeat (delay) tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = data;
      tick();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = 32'hFFFF_FFFF;
      #1;
   endtask

   logic exp_ls;

   initial begin
      bus.if_req_valid  = 1'b0;
      bus.if_addr       = '0;
      bus.if_rsp_ready  = 1'b0;
      bus.ls_req_valid  = 1'b0;
      bus.ls_addr       = '0;
      bus.ls_wen        = 1'b0;
      bus.ls_wdata      = '0;
      bus.ls_wmask      = '0;
      bus.ls_rsp_ready  = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = '0;

      // reset state: all outputs 0, even with both requests pending
      #2;
      bus.if_req_valid = 1'b1;
      bus.ls_req_valid = 1'b1;
      #1;
      check("rst_if_req_ready", bus.if_req_ready, 1'b0);
      check("rst_ls_req_ready", bus.ls_req_ready, 1'b0);
      check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_if_rsp_valid", bus.if_rsp_valid, 1'b0);
      check("rst_ls_rsp_valid", bus.ls_rsp_valid, 1'b0);
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;
      #9 rst_n = 1'b1;
      tick();

      // T1: IF read, memory answers on the third WAIT cycle
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h8000_0000;
      #1;
      check("t1_if_grant", bus.if_req_ready, 1'b1);
      check("t1_ls_no_grant", bus.ls_req_ready, 1'b0);
      tick();
      bus.if_req_valid = 1'b0;
      bus.if_addr      = 32'h1234_5678;
      #1;
      check("t1_mem_req_valid", bus.mem_req_valid, 1'b1);
      check("t1_mem_addr", bus.mem_addr, 32'h8000_0000);
      check("t1_mem_wen", bus.mem_wen, 1'b0);
      check("t1_mem_wmask", bus.mem_wmask, 4'h0);
      serve(2, 32'h0000_0413);
      check("t1_if_rsp_valid", bus.if_rsp_valid, 1'b1);
      check("t1_if_rdata", bus.if_rdata, 32'h0000_0413);
      check("t1_if_rsp_err", bus.if_rsp_err, 1'b0);
      check("t1_ls_rsp_valid", bus.ls_rsp_valid, 1'b0);
      bus.if_rsp_ready = 1'b1;
      tick();
      bus.if_rsp_ready = 1'b0;
      #1;
      check("t1_if_rsp_done", bus.if_rsp_valid, 1'b0);

      // T2: LS write, minimum latency (grant N -> rsp_valid N+3)
      bus.ls_req_valid = 1'b1;
      bus.ls_addr      = 32'h8000_1000;
      bus.ls_wen       = 1'b1;
      bus.ls_wdata     = 32'hDEAD_BEEF;
      bus.ls_wmask     = 4'hF;
      #1;
      check("t2_ls_grant", bus.ls_req_ready, 1'b1);
      check("t2_if_no_grant", bus.if_req_ready, 1'b0);
      tick();
      bus.ls_req_valid = 1'b0;
      bus.ls_wdata     = 32'h0;
      bus.ls_wmask     = 4'h0;
      #1;
      check("t2_mem_wen", bus.mem_wen, 1'b1);
      check("t2_mem_wmask", bus.mem_wmask, 4'hF);
      check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      check("t2_mem_addr", bus.mem_addr, 32'h8000_1000);
      serve(0, 32'hCAFE_F00D);
      check("t2_ls_rsp_valid", bus.ls_rsp_valid, 1'b1);
      check("t2_ls_rdata_write", bus.ls_rdata, 32'h0);
      check("t2_ls_rsp_err", bus.ls_rsp_err, 1'b0);
      check("t2_if_rsp_valid", bus.if_rsp_valid, 1'b0);
      bus.ls_rsp_ready = 1'b1;
      tick();
      bus.ls_rsp_ready = 1'b0;
      bus.ls_wen       = 1'b0;

      // T3: both requesters valid for four transactions
      bus.if_req_valid = 1'b1;
      bus.ls_req_valid = 1'b1;
      bus.ls_wmask     = 4'hF;
      for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060191_ARB_RR_EN
         exp_ls = (i % 2) == 1;
`else
         exp_ls = 1'b1;
`endif
         bus.ls_addr = 32'h0000_0100 + 32'(i);
         bus.if_addr = 32'h0000_0200 + 32'(i);
         #1;
         check("t3_ls_grant", bus.ls_req_ready, exp_ls);
         check("t3_if_grant", bus.if_req_ready, !exp_ls);
         tick();
         check("t3_no_grant_in_req", bus.if_req_ready | bus.ls_req_ready, 1'b0);
         check("t3_mem_addr", bus.mem_addr, exp_ls ? 32'h0000_0100 + 32'(i) : 32'h0000_0200 + 32'(i));
         check("t3_mem_wmask_read", bus.mem_wmask, 4'h0);
         serve(0, 32'hA000_0000 + 32'(i));
         check("t3_ls_rsp_valid", bus.ls_rsp_valid, exp_ls);
         check("t3_if_rsp_valid", bus.if_rsp_valid, !exp_ls);
         check("t3_rdata", exp_ls ? bus.ls_rdata : bus.if_rdata, 32'hA000_0000 + 32'(i));
         if (exp_ls) bus.ls_rsp_ready = 1'b1;
         else        bus.if_rsp_ready = 1'b1;
         tick();
         bus.ls_rsp_ready = 1'b0;
         bus.if_rsp_ready = 1'b0;
      end
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;
      bus.ls_wmask     = 4'h0;

      // T4: no memory response -> error after exactly TIMEOUT WAIT cycles
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h8000_0010;
      #1;
      check("t4_if_grant", bus.if_req_ready, 1'b1);
      tick();
      bus.if_req_valid  = 1'b0;
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      bus.mem_rdata     = 32'h5555_5555;
      for (int k = 1; k < TIMEOUT; k++) begin
         tick();
         check("t4_still_waiting", bus.if_rsp_valid, 1'b0);
      end
      tick();
      check("t4_to_rsp_valid", bus.if_rsp_valid, 1'b1);
      check("t4_to_rdata", bus.if_rdata, 32'h0);
      check("t4_to_err", bus.if_rsp_err, 1'b1);
      // a late memory strobe in RESP must be ignored
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 32'h0000_0077;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check("t4_late_rsp_rdata", bus.if_rdata, 32'h0);
      check("t4_late_rsp_err", bus.if_rsp_err, 1'b1);
      bus.if_rsp_ready = 1'b1;
      tick();
      bus.if_rsp_ready = 1'b0;

      // T4b: response in the timeout cycle wins
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h8000_0020;
      tick();
      bus.if_req_valid = 1'b0;
      serve(TIMEOUT - 1, 32'h0BAD_CAFE);
      check("t4b_rsp_valid", bus.if_rsp_valid, 1'b1);
      check("t4b_rdata", bus.if_rdata, 32'h0BAD_CAFE);
      check("t4b_err", bus.if_rsp_err, 1'b0);
      bus.if_rsp_ready = 1'b1;
      tick();
      bus.if_rsp_ready = 1'b0;

      // T5: IF holds off its response for 5 cycles while LS waits
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h8000_0030;
      tick();
      bus.if_req_valid = 1'b0;
      serve(0, 32'h1111_2222);
      bus.ls_req_valid = 1'b1;
      bus.ls_wen       = 1'b0;
      bus.ls_addr      = 32'h8000_0040;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("t5_rsp_held", bus.if_rsp_valid, 1'b1);
         check("t5_rdata_held", bus.if_rdata, 32'h1111_2222);
         check("t5_no_ls_grant", bus.ls_req_ready, 1'b0);
         tick();
      end
      bus.if_rsp_ready = 1'b1;
      tick();
      bus.if_rsp_ready = 1'b0;
      #1;
      check("t5_if_rsp_done", bus.if_rsp_valid, 1'b0);
      check("t5_ls_grant_after", bus.ls_req_ready, 1'b1);
      tick();
      bus.ls_req_valid = 1'b0;

      // T6: reset during WAIT abandons the LS read silently
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("t6_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("t6_mem_addr", bus.mem_addr, 32'h0);
      check("t6_ls_rsp_valid", bus.ls_rsp_valid, 1'b0);
      check("t6_ls_rdata", bus.ls_rdata, 32'h0);
      #2 rst_n = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 32'h0000_0099;
      tick();
      bus.mem_rsp_valid = 1'b0;
      #1;
      check("t6_late_ls_rsp", bus.ls_rsp_valid, 1'b0);
      check("t6_late_if_rsp", bus.if_rsp_valid, 1'b0);
      check("t6_late_mem_req", bus.mem_req_valid, 1'b0);
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'h8000_0050;
      #1;
      check("t6_next_grant", bus.if_req_ready, 1'b1);
      tick();
      bus.if_req_valid = 1'b0;
      check("t6_next_mem_addr", bus.mem_addr, 32'h8000_0050);
      serve(0, 32'h0000_ABCD);
      check("t6_next_rsp_valid", bus.if_rsp_valid, 1'b1);
      check("t6_next_rdata", bus.if_rdata, 32'h0000_ABCD);
      bus.if_rsp_ready = 1'b1;
      tick();
      bus.if_rsp_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
